btb_update_queue: RTL and testbench
===================================

// Module: btb_update_queue
// PURPOSE
//  Buffers taken-branch resolutions from up to NUM_IN execute lanes per cycle and drains them one per
//  cycle into the single BTB write port (resolving_valid/resolving_branch_PC/resolving_target_PC).
//  Sits between branch resolution and btb. Coalesces repeat updates to the same branch PC.
//  Drops on overflow, since BTB contents are only a hint.
// PARAMETERS
//  NUM_IN  `N  resolution lanes per cycle
//  DEPTH   8   queue entries (power of 2, >= NUM_IN)
// PORTS
//  clock                input   1            single clock, rising edge
//  reset                input   1            asynchronous, active-low reset
//  in_valid             input   NUM_IN       lane carries a resolved branch
//  in_taken             input   NUM_IN       branch resolved taken
//  in_branch_PC         input   NUM_IN x ADDR  PC of the resolved branch
//  in_target_PC         input   NUM_IN x ADDR  resolved target
//  drain_en             input   1            allow dequeue this cycle
//  resolving_valid      output  1            BTB write strobe
//  resolving_branch_PC  output  ADDR         head entry branch PC
//  resolving_target_PC  output  ADDR         head entry target
//  count                output  clog2(DEPTH+1)  occupied entries (registered)
//  drop_count           output  16           saturating count of dropped updates
// BEHAVIOUR
//  - Reset (reset==0, async): queue empty, head=tail=0, count=0, drop_count=0, resolving_valid=0;
//    PC outputs are 0. All outputs stay 0 while reset is held.
//  - Storage: circular FIFO of {branch_PC, target_PC}. head/tail wrap modulo DEPTH.
//  - Output: combinational from the registered head entry.
//    resolving_valid = drain_en && count!=0. No ready back-pressure: BTB accepts every strobe.
//  - Dequeue: when resolving_valid is 1, head advances at the clock edge.
//  - Eligibility: a lane is eligible iff in_valid && in_taken. Not-taken or invalid lanes are ignored.
//  - Intra-cycle duplicates: eligible lanes with equal branch_PC collapse into the highest lane index.
//    The highest lane's target is kept; lower lanes are neither stored nor dropped.
//  - Coalesce: an eligible lane whose branch_PC matches a stored entry overwrites that entry's
//    target_PC in place and uses no slot. The head entry is excluded from the match when it is
//    dequeued in the same cycle; that lane then enqueues as new.
//  - Enqueue: remaining lanes are written in ascending lane order at tail, tail+1, ...
//    Free space = DEPTH - count as sampled at the start of the cycle. A slot freed by a
//    same-cycle dequeue is NOT reusable until the next cycle.
//  - Overflow: lanes beyond free space are dropped. drop_count += number dropped, saturating at 0xFFFF.
//  - count_next = count + enq - deq; it never exceeds DEPTH and never underflows.
//  - Latency: an update accepted at edge t is visible on the outputs after edge t
//    (1 cycle minimum, empty queue, drain_en=1). A coalesced target is visible after the same edge.
//  - Ordering: FIFO. A coalesced entry keeps its original position.
// TESTING
//  1 Reset: assert reset=0 mid-traffic with count=5 -> count=0, resolving_valid=0, drop_count=0
//    immediately, without waiting for a clock edge.
//  2 Single update: lane0 {PC=0x100, tgt=0x200, taken}, drain_en=1 -> next cycle
//    resolving_valid=1, 0x100/0x200. One cycle later count=0, valid=0.
//  3 Coalesce: drain_en=0. Enqueue 0x100->0x200, then next cycle 0x100->0x300 -> count=1.
//    With drain_en=1, a single write 0x100/0x300 is issued.
//  4 Intra-cycle duplicate: lane0 0x40->0x80, lane1 0x40->0xC0 (N=2) -> one entry, 0x40/0xC0, count=1.
//  5 Overflow: drain_en=0. Fill to 8 entries, then present 2 new taken PCs -> count stays 8,
//    drop_count=2. Not-taken lanes present at the same time do not increment drop_count.
//  6 Wrap plus simultaneous events: 20 cycles, each enqueueing 1 and dequeueing 1 with distinct PCs
//    -> outputs appear in exact issue order, count constant, no drops across head/tail wrap.

Source files
------------

// File: rtl/btb_update_queue_if.sv
// btb_update_queue_if
//  Bundles the branch-resolution lanes and the BTB write port of btb_update_queue.
//  master : resolution side (drives lanes and drain_en, observes the BTB strobe)
//  slave  : the queue itself
//  Signals:
//    in_valid/in_taken      [NUM_IN]        per-lane resolution flags
//    in_branch_PC/target_PC [NUM_IN][ADDR]  per-lane branch and target
//    drain_en                               allow dequeue this cycle
//    resolving_valid/_branch_PC/_target_PC  BTB write port
interface btb_update_queue_if #(
  parameter int NUM_IN = 2,
  parameter int ADDR   = 32
);
  logic [NUM_IN-1:0]           in_valid;
  logic [NUM_IN-1:0]           in_taken;
  logic [NUM_IN-1:0][ADDR-1:0] in_branch_PC;
  logic [NUM_IN-1:0][ADDR-1:0] in_target_PC;
  logic                        drain_en;
  logic                        resolving_valid;
  logic [ADDR-1:0]             resolving_branch_PC;
  logic [ADDR-1:0]             resolving_target_PC;

  modport master (
    output in_valid, in_taken, in_branch_PC, in_target_PC, drain_en,
    input  resolving_valid, resolving_branch_PC, resolving_target_PC
  );
  modport slave (
    input  in_valid, in_taken, in_branch_PC, in_target_PC, drain_en,
    output resolving_valid, resolving_branch_PC, resolving_target_PC
  );
endinterface

// File: rtl/btb_update_queue.sv
// btb_update_queue
//  Buffers taken-branch resolutions from NUM_IN lanes and drains them one per cycle
//  into the BTB write port. Repeat updates to a queued PC overwrite the queued target
//  in place; updates that find no free slot are dropped and counted.
//  Ports:
//    clock       rising-edge clock
//    reset       asynchronous active-low reset
//    bus         btb_update_queue_if.slave (lanes in, BTB write port out)
//    count       occupied entries (registered)
//    drop_count  saturating count of dropped updates

// Per-lane lookup of the lane's branch PC against the queued entries.
module btb_uq_lane #(
  parameter int DEPTH = 8,
  parameter int ADDR  = 32,
  parameter int PW    = 3
) (
  input  logic [ADDR-1:0]            lane_pc,
  input  logic [DEPTH-1:0][ADDR-1:0] ent_pc,
  input  logic [DEPTH-1:0]           ent_en,
  output logic                       hit,
  output logic [PW-1:0]              hit_idx
);
  // Queued PCs are unique, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_en[e] && ent_pc[e] == lane_pc) begin
        hit     = 1'b1;
        hit_idx = PW'(e);
      end
    end
  end
endmodule

module btb_update_queue #(
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR   = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  btb_update_queue_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [15:0]                  drop_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][ADDR-1:0] ent_pc, ent_tgt;
  logic [DEPTH-1:0]           ent_vld;
  logic [PW-1:0]              head, tail;

  logic                       deq;
  logic [DEPTH-1:0]           ent_en;
  logic [NUM_IN-1:0]          hit;
  logic [NUM_IN-1:0][PW-1:0]  hit_idx;
  logic [NUM_IN-1:0]          live, co_en, wr_en;
  logic [NUM_IN-1:0][PW-1:0]  wr_slot;
  logic [CW-1:0]              free, rank, enq_n, drop_n;
  logic [16:0]                dsum;

  assign deq                     = bus.drain_en && (count != '0);
  assign bus.resolving_valid     = deq;
  assign bus.resolving_branch_PC = ent_pc[head];
  assign bus.resolving_target_PC = ent_tgt[head];

  // The head leaving this cycle cannot absorb a coalesce; a matching lane re-enqueues.
  always_comb begin
    ent_en = ent_vld;
    if (deq) ent_en[head] = 1'b0;
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    btb_uq_lane #(.DEPTH(DEPTH), .ADDR(ADDR), .PW(PW)) u_lane (
      .lane_pc (bus.in_branch_PC[i]),
      .ent_pc  (ent_pc),
      .ent_en  (ent_en),
      .hit     (hit[i]),
      .hit_idx (hit_idx[i])
    );
  end

  // Lane selection: collapse duplicates onto the highest lane, then coalesce or
  // allocate in ascending lane order. Free space is start-of-cycle, so a slot
  // vacated by this cycle's dequeue is not handed out.
  always_comb begin
    live    = '0;
    co_en   = '0;
    wr_en   = '0;
    wr_slot = '0;
    rank    = '0;
    enq_n   = '0;
    drop_n  = '0;
    free    = CW'(DEPTH) - count;
    for (int i = 0; i < NUM_IN; i++) begin
      live[i] = bus.in_valid[i] && bus.in_taken[i];
      for (int j = i + 1; j < NUM_IN; j++) begin
        if (bus.in_valid[j] && bus.in_taken[j] &&
            bus.in_branch_PC[j] == bus.in_branch_PC[i])
          live[i] = 1'b0;
      end
      if (live[i] && hit[i]) begin
        co_en[i] = 1'b1;
      end else if (live[i]) begin
        if (rank < free) begin
          wr_en[i]   = 1'b1;
          wr_slot[i] = tail + PW'(rank);
          enq_n      = enq_n + 1'b1;
        end else begin
          drop_n = drop_n + 1'b1;
        end
        rank = rank + 1'b1;
      end
    end
  end

  assign dsum = {1'b0, drop_count} + 17'(drop_n);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_pc     <= '0;
      ent_tgt    <= '0;
      ent_vld    <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      // Dequeue clear first; new writes never target the departing head slot.
      if (deq) ent_vld[head] <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (wr_en[i]) begin
          ent_pc[wr_slot[i]]  <= bus.in_branch_PC[i];
          ent_tgt[wr_slot[i]] <= bus.in_target_PC[i];
          ent_vld[wr_slot[i]] <= 1'b1;
        end
        if (co_en[i]) ent_tgt[hit_idx[i]] <= bus.in_target_PC[i];
      end
      head       <= head + PW'(deq);
      tail       <= tail + PW'(enq_n);
      count      <= count + enq_n - CW'(deq);
      drop_count <= dsum[16] ? 16'hFFFF : dsum[15:0];
    end
  end
endmodule

// File: tb/tb_btb_update_queue.sv
// tb_btb_update_queue
//  Directed bench for btb_update_queue (NUM_IN=2, DEPTH=8, ADDR=32). Inputs are driven
//  and outputs sampled 1 time unit after each rising edge.
module tb_btb_update_queue;
  localparam int NUM_IN = 2;
  localparam int DEPTH  = 8;
  localparam int ADDR   = 32;

  logic        clock;
  logic        reset;
  logic [3:0]  count;
  logic [15:0] drop_count;
  int          n_cmp, n_err;

  btb_update_queue_if #(.NUM_IN(NUM_IN), .ADDR(ADDR)) bus ();

  btb_update_queue #(.NUM_IN(NUM_IN), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .count      (count),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    bus.in_valid     = '0;
    bus.in_taken     = '0;
    bus.in_branch_PC = '0;
    bus.in_target_PC = '0;
  endtask

  task automatic lane(input int i, input logic v, input logic t,
                      input logic [31:0] pc, input logic [31:0] tgt);
    bus.in_valid[i]     = v;
    bus.in_taken[i]     = t;
    bus.in_branch_PC[i] = pc;
    bus.in_target_PC[i] = tgt;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] tgt);
    chk({tag, ".vld"}, 32'(bus.resolving_valid), 32'd1);
    chk({tag, ".pc"},  bus.resolving_branch_PC, pc);
    chk({tag, ".tgt"}, bus.resolving_target_PC, tgt);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.drain_en = 1'b1;
    clr();
    #2;
    chk("rst.count", 32'(count), 0);
    chk("rst.vld",   32'(bus.resolving_valid), 0);
    chk("rst.drop",  32'(drop_count), 0);
    chk("rst.pc",    bus.resolving_branch_PC, 0);
    chk("rst.tgt",   bus.resolving_target_PC, 0);
    tick();
    reset = 1'b1;
    tick();

    // single update, minimum latency
    lane(0, 1, 1, 32'h100, 32'h200);
    tick();
    clr();
    chk_out("single", 32'h100, 32'h200);
    chk("single.count", 32'(count), 1);
    tick();
    chk("single.count0", 32'(count), 0);
    chk("single.vld0", 32'(bus.resolving_valid), 0);

    // coalesce across cycles
    bus.drain_en = 1'b0;
    lane(0, 1, 1, 32'h100, 32'h200);
    tick();
    lane(0, 1, 1, 32'h100, 32'h300);
    tick();
    clr();
    chk("coal.count", 32'(count), 1);
    chk("coal.vld_off", 32'(bus.resolving_valid), 0);
    bus.drain_en = 1'b1;
    #1;
    chk_out("coal", 32'h100, 32'h300);
    tick();
    chk("coal.count0", 32'(count), 0);

    // intra-cycle duplicate collapses onto the higher lane
    bus.drain_en = 1'b0;
    lane(0, 1, 1, 32'h40, 32'h80);
    lane(1, 1, 1, 32'h40, 32'hC0);
    tick();
    clr();
    chk("dup.count", 32'(count), 1);
    bus.drain_en = 1'b1;
    #1;
    chk_out("dup", 32'h40, 32'hC0);
    tick();
    chk("dup.count0", 32'(count), 0);
    chk("dup.drop", 32'(drop_count), 0);

    // head being dequeued is excluded from coalescing
    bus.drain_en = 1'b0;
    lane(0, 1, 1, 32'h500, 32'h600);
    tick();
    bus.drain_en = 1'b1;
    lane(0, 1, 1, 32'h500, 32'h700);
    #1;
    chk_out("hx.old", 32'h500, 32'h600);
    tick();
    clr();
    chk("hx.count", 32'(count), 1);
    chk_out("hx.new", 32'h500, 32'h700);
    tick();
    chk("hx.count0", 32'(count), 0);

    // overflow
    bus.drain_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      lane(0, 1, 1, 32'h1000 + 32'(8*c), 32'h11000 + 32'(8*c));
      lane(1, 1, 1, 32'h1004 + 32'(8*c), 32'h11004 + 32'(8*c));
      tick();
    end
    clr();
    chk("ovf.full", 32'(count), 8);
    lane(0, 1, 1, 32'h2000, 32'h3000);
    lane(1, 1, 1, 32'h2004, 32'h3004);
    tick();
    chk("ovf.count", 32'(count), 8);
    chk("ovf.drop2", 32'(drop_count), 2);
    lane(0, 1, 0, 32'h2008, 32'h3008);
    lane(1, 0, 1, 32'h200C, 32'h300C);
    tick();
    chk("ovf.nt_drop", 32'(drop_count), 2);
    lane(0, 1, 1, 32'h1000, 32'hAAAA);
    clr();
    lane(0, 1, 1, 32'h1000, 32'hAAAA);
    tick();
    chk("ovf.coal_count", 32'(count), 8);
    chk("ovf.coal_drop", 32'(drop_count), 2);
    // slot freed by this cycle's dequeue is not reusable
    bus.drain_en = 1'b1;
    lane(0, 1, 1, 32'h3000, 32'h4000);
    #1;
    chk_out("ovf.h0", 32'h1000, 32'hAAAA);
    tick();
    clr();
    chk("ovf.freed_count", 32'(count), 7);
    chk("ovf.freed_drop", 32'(drop_count), 3);
    for (int k = 1; k < 8; k++) begin
      chk_out($sformatf("ovf.h%0d", k), 32'h1000 + 32'(4*k), 32'h11000 + 32'(4*k));
      tick();
    end
    chk("ovf.count0", 32'(count), 0);

    // wrap with simultaneous enqueue/dequeue
    bus.drain_en = 1'b0;
    lane(0, 1, 1, 32'h8000, 32'h9000);
    lane(1, 1, 1, 32'h8004, 32'h9004);
    tick();
    clr();
    lane(0, 1, 1, 32'h8008, 32'h9008);
    tick();
    bus.drain_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      lane(0, 1, 1, 32'h8000 + 32'(4*(c+3)), 32'h9000 + 32'(4*(c+3)));
      #1;
      chk_out($sformatf("wrap%0d", c), 32'h8000 + 32'(4*c), 32'h9000 + 32'(4*c));
      tick();
      chk($sformatf("wrap%0d.count", c), 32'(count), 3);
    end
    clr();
    chk("wrap.drop", 32'(drop_count), 3);

    // async reset mid-traffic
    bus.drain_en = 1'b0;
    lane(0, 1, 1, 32'hA000, 32'hB000);
    lane(1, 1, 1, 32'hA004, 32'hB004);
    tick();
    chk("ar.count5", 32'(count), 5);
    bus.drain_en = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("ar.count", 32'(count), 0);
    chk("ar.vld",   32'(bus.resolving_valid), 0);
    chk("ar.drop",  32'(drop_count), 0);
    chk("ar.pc",    bus.resolving_branch_PC, 0);
    tick();
    chk("ar.hold", 32'(count), 0);
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
